// File: rtl/counter_dec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : counter_dec_ctrl
// Purpose  : Sequencer for a two-digit BCD counter: preset load, prescaled
//            up/down stepping, pause / restart / abort and completion flag.
// Options  : COUNTER_DEC_CTRL_AUTORELOAD_EN - one-cycle DONE, then reload
// Revision : 1.0 - initial release
// ============================================================================
module counter_dec_ctrl #(
  parameter int DIV   = 1000,
  parameter int DIV_W = $clog2(DIV)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_pause,
  input  logic            i_abort,
  input  logic            i_dir,
  input  logic [1:0][3:0] i_preset,
  input  logic [1:0][3:0] i_count,
  input  logic            i_zero,
  output logic            o_load,
  output logic [1:0][3:0] o_value,
  output logic            o_plus,
  output logic            o_minus,
  output logic            o_busy,
  output logic            o_done,
  output logic [2:0]      o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [DIV_W-1:0] c_presc_last = DIV_W'(DIV - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DIV_W-1:0]  r_presc;
  logic [DIV_W-1:0]  w_presc_nxt;
  logic [DIV_W-1:0]  w_presc_inc;
  logic              r_stepped;
  logic              r_dir;
  logic [1:0][3:0]   r_target;
  logic [1:0][3:0]   w_preset_clamped;
  logic              w_complete;
  logic              w_latch;
  logic              w_step;

  function automatic logic [3:0] f_clamp(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign w_preset_clamped = {f_clamp(i_preset[1]), f_clamp(i_preset[0])};
  assign w_presc_inc      = (r_presc == c_presc_last) ? '0 : r_presc + DIV_W'(1);
  // Completion is only meaningful the cycle after a step, once the counter has moved.
  assign w_complete       = r_dir ? (i_count == r_target) : i_zero;

  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = '0;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_LOAD;
          w_latch     = 1'b1;
        end
      end
      S_LOAD: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (i_start) begin
          w_state_nxt = S_LOAD;
          w_latch     = 1'b1;
        end else if (r_target == '0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_presc_nxt = w_presc_inc;
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (i_start) begin
          w_state_nxt = S_LOAD;
          w_latch     = 1'b1;
        end else if (r_stepped && w_complete) begin
          w_state_nxt = S_DONE;
        end else if (i_pause) begin
          w_state_nxt = S_PAUSE;
        end
      end
      S_PAUSE: begin
        w_presc_nxt = r_presc;
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (i_start) begin
          w_state_nxt = S_LOAD;
          w_latch     = 1'b1;
        end else if (r_stepped && w_complete) begin
          w_state_nxt = S_DONE;
        end else if (i_pause) begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (i_start) begin
          w_state_nxt = S_LOAD;
          w_latch     = 1'b1;
        end
`ifdef COUNTER_DEC_CTRL_AUTORELOAD_EN
        else begin
          w_state_nxt = S_LOAD;
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Pulses are registered, so the step is decided one cycle ahead from the next state.
    w_step = (w_state_nxt == S_RUN) && (w_presc_nxt == c_presc_last);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= S_IDLE;
      r_presc   <= '0;
      r_stepped <= 1'b0;
      r_dir     <= 1'b0;
      r_target  <= '0;
      o_load    <= 1'b0;
      o_value   <= '0;
      o_plus    <= 1'b0;
      o_minus   <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_presc   <= w_presc_nxt;
      r_stepped <= o_plus | o_minus;
      o_load    <= (w_state_nxt == S_LOAD);
      o_busy    <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_RUN) ||
                   (w_state_nxt == S_PAUSE);
      o_done    <= (w_state_nxt == S_DONE);
      o_plus    <= w_step & r_dir;
      o_minus   <= w_step & ~r_dir;
      if (w_latch) begin
        r_dir    <= i_dir;
        r_target <= w_preset_clamped;
        o_value  <= i_dir ? '0 : w_preset_clamped;
      end
    end
  end

  assign o_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_counter_dec_ctrl.sv
`default_nettype none
// tb_counter_dec_ctrl: directed and randomized checks of counter_dec_ctrl against
// a step-schedule reference model and a behavioural two-digit counter.
module tb_counter_dec_ctrl;
  localparam int DIV = 4;
`ifdef COUNTER_DEC_CTRL_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            start, pause, abort, dir;
  logic [1:0][3:0] preset;
  logic [1:0][3:0] count;
  logic            zero;
  logic            load, plus, minus, busy, done;
  logic [1:0][3:0] value;
  logic [2:0]      state;

  counter_dec_ctrl #(.DIV(DIV)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_start(start), .i_pause(pause), .i_abort(abort),
    .i_dir(dir), .i_preset(preset), .i_count(count), .i_zero(zero),
    .o_load(load), .o_value(value), .o_plus(plus), .o_minus(minus),
    .o_busy(busy), .o_done(done), .o_state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int bcd2int(input logic [1:0][3:0] v);
    return int'(v[1]) * 10 + int'(v[0]);
  endfunction

  function automatic int clampd(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  // Behavioural two-digit decimal counter driven by the controller
  int cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt <= 0;
    else if (load)  cnt <= bcd2int(value);
    else if (plus)  cnt <= (cnt + 1) % 100;
    else if (minus) cnt <= (cnt + 99) % 100;
  end
  assign count = {4'(cnt / 10), 4'(cnt % 10)};
  assign zero  = (cnt == 0);

  // Reference model: tracks the cycle of the next step and the steps remaining
  int cyc = 0;
  int m_st, m_dir, m_tgt, m_val, m_left, m_next, m_chk;
  int e_st, e_load, e_plus, e_minus, e_busy, e_done, e_val;

  task automatic model_outputs(input int k);
    bit s;
    e_st    = m_st;
    e_load  = (m_st == 1);
    e_busy  = (m_st == 1 || m_st == 2 || m_st == 3);
    e_done  = (m_st == 4);
    s       = (m_st == 2) && (m_next == k);
    e_plus  = s && m_dir;
    e_minus = s && !m_dir;
    e_val   = m_val;
  endtask

  task automatic model_reset();
    m_st = 0; m_dir = 0; m_tgt = 0; m_val = 0; m_left = 0; m_next = -1; m_chk = -1;
    model_outputs(cyc);
  endtask

  task automatic enter_load(input int k);
    m_st = 1; m_left = m_tgt; m_next = k + 1 + DIV; m_chk = -1;
  endtask

  task automatic do_start(input int k);
    m_dir = dir;
    m_tgt = clampd(preset[1]) * 10 + clampd(preset[0]);
    m_val = dir ? 0 : m_tgt;
    enter_load(k);
  endtask

  task automatic model_step();
    int k;
    bit fin;
    k = cyc;
    if (m_st == 2 && m_next == k) begin
      m_left--; m_chk = k + 1; m_next += DIV;
    end
    fin = (m_chk == k) && (m_left == 0);
    case (m_st)
      0: if (start) do_start(k);
      1: if (abort) m_st = 0; else if (start) do_start(k); else m_st = (m_left == 0) ? 4 : 2;
      2: if (abort) m_st = 0; else if (start) do_start(k); else if (fin) m_st = 4;
         else if (pause) m_st = 3;
      3: begin
        m_next++;
        if (abort) m_st = 0; else if (start) do_start(k); else if (fin) m_st = 4;
        else if (pause) m_st = 2;
      end
      4: if (abort) m_st = 0; else if (start) do_start(k); else if (AUTO) enter_load(k);
      default: m_st = 0;
    endcase
    cyc = k + 1;
    model_outputs(cyc);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  bit chk_en = 0;
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("state", int'(state), e_st);
      check("load",  int'(load),  e_load);
      check("value", bcd2int(value), e_val);
      check("plus",  int'(plus),  e_plus);
      check("minus", int'(minus), e_minus);
      check("busy",  int'(busy),  e_busy);
      check("done",  int'(done),  e_done);
    end
  end

  int q_pulse[$];
  int load_cyc, load_val;
  initial forever begin
    @(negedge clk);
    if (plus || minus) q_pulse.push_back(cyc);
    if (load) begin load_cyc = cyc; load_val = bcd2int(value); end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int max, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < max; i++) begin
      if (done) begin dcyc = cyc; break; end
      tick();
    end
    if (dcyc < 0) check("done_timeout", 0, 1);
  endtask

  task automatic wait_pulses(input int n, input int max);
    for (int i = 0; i < max && q_pulse.size() < n; i++) tick();
    if (q_pulse.size() < n) check("pulse_timeout", q_pulse.size(), n);
  endtask

  task automatic do_start_in(input logic d, input logic [3:0] tens, input logic [3:0] units,
                             output int s);
    preset = {tens, units}; dir = d; start = 1'b1; s = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    int s, d, d2, d3, n, nd;
    start = 0; pause = 0; abort = 0; dir = 0; preset = '0;
    rst_n = 0;
    tick();
    chk_en = 1;
    tick();
    check("rst_state", int'(state), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1;
    repeat (3) tick();

    // Down run from 03
    q_pulse.delete();
    do_start_in(1'b0, 4'd0, 4'd3, s);
    wait_done(60, d);
    check("dn_load_cyc", load_cyc - s, 1);
    check("dn_load_val", load_val, 3);
    check("dn_npulse", q_pulse.size(), 3);
    if (q_pulse.size() == 3) begin
      check("dn_step1", q_pulse[0] - s, 5);
      check("dn_step2", q_pulse[1] - s, 9);
      check("dn_step3", q_pulse[2] - s, 13);
    end
    check("dn_done_cyc", d - s, 15);
    check("dn_cnt", cnt, 0);
    if (!AUTO) begin
      repeat (5) tick();
      check("dn_done_hold", int'(done), 1);
    end
    do_abort();
    check("dn_abort_state", int'(state), 0);

    // Up run to 12
    q_pulse.delete();
    do_start_in(1'b1, 4'd1, 4'd2, s);
    wait_done(100, d);
    check("up_load_val", load_val, 0);
    check("up_npulse", q_pulse.size(), 12);
    if (q_pulse.size() == 12) begin
      for (int i = 1; i < 12; i++) check("up_spacing", q_pulse[i] - q_pulse[i-1], 4);
      check("up_done_lag", d - q_pulse[11], 2);
    end
    check("up_cnt", cnt, 12);
    do_abort();

    // Pause for 10 cycles after the second step, then abort
    q_pulse.delete();
    do_start_in(1'b0, 4'd0, 4'd5, s);
    wait_pulses(2, 40);
    pause = 1; tick(); pause = 0;
    check("pause_state", int'(state), 3);
    repeat (9) tick();
    pause = 1; tick(); pause = 0;
    wait_pulses(3, 40);
    if (q_pulse.size() >= 3) check("pause_shift", q_pulse[2] - q_pulse[1], 14);
    repeat (2) tick();
    do_abort();
    check("abort_state", int'(state), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    n = q_pulse.size();
    repeat (12) tick();
    check("abort_no_pulse", q_pulse.size(), n);

    // Preset 00, down
    q_pulse.delete();
    do_start_in(1'b0, 4'd0, 4'd0, s);
    check("p00_load", int'(state), 1);
    tick();
    check("p00_done_state", int'(state), 4);
    check("p00_done", int'(done), 1);
    check("p00_no_pulse", q_pulse.size(), 0);
    do_abort();

    // Out-of-range digits clamp
    do_start_in(1'b0, 4'hA, 4'hF, s);
    check("clamp_value", int'(value), 8'h99);
    do_abort();

    // Start and abort together from RUN
    do_start_in(1'b0, 4'd0, 4'd5, s);
    repeat (3) tick();
    start = 1; abort = 1; tick(); start = 0; abort = 0;
    check("sa_state", int'(state), 0);
    check("sa_load", int'(load), 0);

    // Asynchronous reset mid-run
    do_start_in(1'b0, 4'd0, 4'd7, s);
    repeat (6) tick();
    #2 rst_n = 0;
    #1;
    check("arst_state", int'(state), 0);
    check("arst_load", int'(load), 0);
    check("arst_value", int'(value), 0);
    check("arst_plus", int'(plus), 0);
    check("arst_minus", int'(minus), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    tick();
    rst_n = 1;
    repeat (5) tick();
    check("post_rst_idle", int'(state), 0);

`ifdef COUNTER_DEC_CTRL_AUTORELOAD_EN
    // Periodic operation from 02
    do_start_in(1'b0, 4'd0, 4'd2, s);
    wait_done(40, d);
    tick(); tick();
    check("ar_reload1", cnt, 2);
    wait_done(40, d2);
    check("ar_period1", d2 - d, 2 * DIV + 3);
    tick(); tick();
    check("ar_reload2", cnt, 2);
    wait_done(40, d3);
    check("ar_period2", d3 - d2, 2 * DIV + 3);
    do_abort();
    nd = 0;
    repeat (30) begin
      tick();
      if (done) nd++;
    end
    check("ar_stopped", nd, 0);
`endif

    // Randomized traffic checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 99) == 0);
      pause = ($urandom_range(0, 29) == 0);
      abort = ($urandom_range(0, 249) == 0);
      dir   = 1'($urandom_range(0, 1));
      preset[1] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
      preset[0] = 4'($urandom_range(0, 15));
      tick();
    end
    start = 0; pause = 0; abort = 0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
